mem_access_stage: RTL and testbench

- MEM stage of the 5-stage RV32I pipeline.
- Consumes the EX/MEM register that execute produces and issues word loads and stores to a data-memory port over a valid/ready request, valid response handshake.
- Registers the MEM/WB record consumed by writeback and by the forwarding path.
- Stalls upstream while an access is outstanding.

---
 rtl/execute_pkg.sv | 14 +
 rtl/memory_pkg.sv | 18 +
 rtl/mem_access_stage.sv | 108 ++++++++++
 tb/tb_mem_access_stage.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/execute_pkg.sv
// execute_pkg: EX/MEM pipeline record produced by the execute stage
package execute_pkg;

    typedef struct packed {
        logic [31:0] alu_result;
        logic [31:0] rs2_data;
        logic [4:0]  rd;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        mem_to_reg;
    } ex_mem_t;

endpackage

// File: rtl/memory_pkg.sv
// memory_pkg: MEM/WB record, MEM stage FSM states and data-memory constants
package memory_pkg;

    typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP} mem_state_e;

    localparam logic [3:0] WSTRB_WORD = 4'hF;

    typedef struct packed {
        logic [4:0]  rd;
        logic        reg_write;
        logic        mem_to_reg;
        logic [31:0] mem_data;
        logic [31:0] alu_result;
    } mem_wb_t;

    localparam mem_wb_t MEM_WB_BUBBLE = '0;

endpackage

// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM stage issuing word loads/stores over a valid/ready data-memory port
module mem_access_stage
    import execute_pkg::*;
    import memory_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 0,
    parameter int unsigned CNT_W          = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  ex_mem_t     ex_mem,
    output logic        dmem_req_valid,
    input  logic        dmem_req_ready,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_wstrb,
    input  logic        dmem_rsp_valid,
    input  logic [31:0] dmem_rdata,
    output logic        mem_stall,
    output mem_wb_t     mem_wb,
    output logic        misaligned_fault,
    output logic        bus_timeout
);

    mem_state_e       state, state_n;
    logic [CNT_W-1:0] cnt;
    mem_wb_t          wb_n;
    logic             mem_op, bad_op, is_store, timed_out;

    assign mem_op    = ex_mem.mem_read ^ ex_mem.mem_write;
    assign bad_op    = (ex_mem.mem_read | ex_mem.mem_write) &&
                       ((ex_mem.mem_read & ex_mem.mem_write) || ex_mem.alu_result[1:0] != 2'b00);
    assign is_store  = ex_mem.mem_write;
    assign timed_out = (TIMEOUT_CYCLES != 0) && (cnt == CNT_W'(TIMEOUT_CYCLES));

    assign dmem_we    = dmem_req_valid & is_store;
    assign dmem_addr  = dmem_req_valid ? ex_mem.alu_result : 32'h0;
    assign dmem_wdata = dmem_req_valid ? ex_mem.rs2_data : 32'h0;
    assign dmem_wstrb = dmem_we ? WSTRB_WORD : 4'h0;

    // Next state, handshake outputs and the MEM/WB record to register; everything quiet during reset
    always_comb begin
        state_n          = state;
        dmem_req_valid   = 1'b0;
        mem_stall        = 1'b0;
        misaligned_fault = 1'b0;
        bus_timeout      = 1'b0;
        wb_n             = MEM_WB_BUBBLE;
        if (!reset) begin
            case (state)
                IDLE, REQ: begin
                    if (state == IDLE && bad_op) begin
                        misaligned_fault = 1'b1;
                    end else if (state == REQ && timed_out) begin
                        bus_timeout = 1'b1;
                        state_n     = IDLE;
                    end else if (state == REQ || mem_op) begin
                        dmem_req_valid = 1'b1;
                        mem_stall      = !(dmem_req_ready && is_store);
                        state_n        = dmem_req_ready ? (is_store ? IDLE : WAIT_RSP) : REQ;
                        if (dmem_req_ready && is_store) begin
                            wb_n.rd         = ex_mem.rd;
                            wb_n.alu_result = ex_mem.alu_result;
                        end
                    end else begin
                        wb_n.rd         = ex_mem.rd;
                        wb_n.reg_write  = ex_mem.reg_write;
                        wb_n.alu_result = ex_mem.alu_result;
                    end
                end
                WAIT_RSP: begin
                    if (dmem_rsp_valid) begin
                        state_n         = IDLE;
                        wb_n.rd         = ex_mem.rd;
                        wb_n.reg_write  = ex_mem.reg_write;
                        wb_n.mem_to_reg = ex_mem.mem_to_reg;
                        wb_n.mem_data   = dmem_rdata;
                        wb_n.alu_result = ex_mem.alu_result;
                    end else if (timed_out) begin
                        bus_timeout = 1'b1;
                        state_n     = IDLE;
                    end else begin
                        mem_stall = 1'b1;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // State, saturating timeout counter (cleared on entry to a waiting state) and MEM/WB register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            mem_wb <= MEM_WB_BUBBLE;
        end else begin
            state  <= state_n;
            mem_wb <= wb_n;
            if (state_n != state)
                cnt <= '0;
            else if (mem_stall && cnt != {CNT_W{1'b1}})
                cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: scoreboard bench for the MEM stage handshake, stalls, faults and timeout
module tb_mem_access_stage;
    import execute_pkg::*;
    import memory_pkg::*;

    logic        clk, reset;
    ex_mem_t     ex_mem;
    logic        dmem_req_valid, dmem_req_ready, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_wstrb;
    logic        dmem_rsp_valid, mem_stall, misaligned_fault, bus_timeout;
    mem_wb_t     mem_wb;

    int total = 0;
    int bad   = 0;
    mem_wb_t sb[$];

    mem_access_stage #(.TIMEOUT_CYCLES(4), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .ex_mem(ex_mem),
        .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
        .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_wstrb(dmem_wstrb), .dmem_rsp_valid(dmem_rsp_valid),
        .dmem_rdata(dmem_rdata), .mem_stall(mem_stall), .mem_wb(mem_wb),
        .misaligned_fault(misaligned_fault), .bus_timeout(bus_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic ex_mem_t mk(input logic [31:0] a, input logic [31:0] d, input logic [4:0] rd,
                                   input logic rw, input logic mr, input logic mw, input logic m2r);
        ex_mem_t e;
        e.alu_result = a; e.rs2_data = d; e.rd = rd;
        e.reg_write = rw; e.mem_read = mr; e.mem_write = mw; e.mem_to_reg = m2r;
        return e;
    endfunction

    function automatic mem_wb_t wb(input logic [4:0] rd, input logic rw, input logic m2r,
                                   input logic [31:0] md, input logic [31:0] a);
        mem_wb_t w;
        w.rd = rd; w.reg_write = rw; w.mem_to_reg = m2r; w.mem_data = md; w.alu_result = a;
        return w;
    endfunction

    // Drive one cycle from a negedge, check combinational outputs, then score the registered MEM/WB
    task automatic step(input string tag, input ex_mem_t e, input logic rdy, input logic rv,
                        input logic [31:0] rdat, input logic x_req, input logic x_stall,
                        input logic x_fault, input logic x_tmo, input mem_wb_t x_wb);
        ex_mem = e; dmem_req_ready = rdy; dmem_rsp_valid = rv; dmem_rdata = rdat;
        #1;
        chk({tag, ".req"},   128'(dmem_req_valid),   128'(x_req));
        chk({tag, ".stall"}, 128'(mem_stall),        128'(x_stall));
        chk({tag, ".fault"}, 128'(misaligned_fault), 128'(x_fault));
        chk({tag, ".tmo"},   128'(bus_timeout),      128'(x_tmo));
        if (x_req) begin
            chk({tag, ".addr"},  128'(dmem_addr),  128'(e.alu_result));
            chk({tag, ".wdata"}, 128'(dmem_wdata), 128'(e.rs2_data));
            chk({tag, ".we"},    128'(dmem_we),    128'(e.mem_write));
            chk({tag, ".wstrb"}, 128'(dmem_wstrb), 128'(e.mem_write ? 4'hF : 4'h0));
        end
        sb.push_back(x_wb);
        @(posedge clk);
        #1;
        chk({tag, ".wb"}, 128'(mem_wb), 128'(sb.pop_front()));
        @(negedge clk);
    endtask

    ex_mem_t alu, ld, ld2, st, mis, both, ldt, ld3;
    mem_wb_t z;

    initial begin
        z = '0;
        alu  = mk(32'h0000_0042, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        ld   = mk(32'h0000_0100, 32'h0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b1);
        ld2  = mk(32'h0000_0108, 32'h0, 5'd8, 1'b1, 1'b1, 1'b0, 1'b1);
        st   = mk(32'h0000_0204, 32'h1234_5678, 5'd9, 1'b1, 1'b0, 1'b1, 1'b0);
        mis  = mk(32'h0000_0102, 32'h0, 5'd3, 1'b1, 1'b1, 1'b0, 1'b1);
        both = mk(32'h0000_0200, 32'h0, 5'd2, 1'b1, 1'b1, 1'b1, 1'b1);
        ldt  = mk(32'h0000_0300, 32'h0, 5'd4, 1'b1, 1'b1, 1'b0, 1'b1);
        ld3  = mk(32'h0000_0400, 32'h0, 5'd11, 1'b1, 1'b1, 1'b0, 1'b1);
        reset = 1'b1; ex_mem = ld; dmem_req_ready = 1'b1; dmem_rsp_valid = 1'b0; dmem_rdata = '0;
        #3;
        chk("rst.req",   128'(dmem_req_valid), 128'(0));
        chk("rst.stall", 128'(mem_stall),      128'(0));
        chk("rst.addr",  128'(dmem_addr),      128'(0));
        chk("rst.wb",    128'(mem_wb),         128'(0));
        @(negedge clk);
        reset = 1'b0;
        // ALU pass-through
        step("alu", alu, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, wb(5'd5, 1'b1, 1'b0, 32'h0, 32'h42));
        // Load, response three cycles after acceptance
        step("ld.acc", ld, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, z);
        step("ld.w1",  ld, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, z);
        step("ld.w2",  ld, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, z);
        step("ld.rsp", ld, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 1'b0,
             wb(5'd7, 1'b1, 1'b1, 32'hDEAD_BEEF, 32'h100));
        // Back-to-back load at minimum latency; rsp_valid during the accept cycle is ignored
        step("ld2.acc", ld2, 1'b1, 1'b1, 32'h1111_1111, 1'b1, 1'b1, 1'b0, 1'b0, z);
        step("ld2.rsp", ld2, 1'b0, 1'b1, 32'hCAFE_F00D, 1'b0, 1'b0, 1'b0, 1'b0,
             wb(5'd8, 1'b1, 1'b1, 32'hCAFE_F00D, 32'h108));
        // Store with ready held low for two cycles
        step("st.i",   st, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, z);
        step("st.r1",  st, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, z);
        step("st.acc", st, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, wb(5'd9, 1'b0, 1'b0, 32'h0, 32'h204));
        // Store accepted immediately (posted)
        step("st2", st, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, wb(5'd9, 1'b0, 1'b0, 32'h0, 32'h204));
        // Misaligned and illegal ops
        step("mis",  mis,  1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, z);
        step("both", both, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, z);
        // Timeout: response never arrives
        step("to.acc", ldt, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, z);
        for (int i = 0; i < 4; i++)
            step("to.wait", ldt, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, z);
        step("to.fire", ldt, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, z);
        step("to.stray", alu, 1'b0, 1'b1, 32'hBAD0_BAD0, 1'b0, 1'b0, 1'b0, 1'b0,
             wb(5'd5, 1'b1, 1'b0, 32'h0, 32'h42));
        // Reset while waiting for a response
        step("rs.acc", ld3, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, z);
        dmem_req_ready = 1'b0;
        reset = 1'b1;
        #1;
        chk("rs.stall", 128'(mem_stall),      128'(0));
        chk("rs.req",   128'(dmem_req_valid), 128'(0));
        chk("rs.wb",    128'(mem_wb),         128'(0));
        @(negedge clk);
        reset = 1'b0;
        step("rs.rsp_ign", alu, 1'b0, 1'b1, 32'h5555_5555, 1'b0, 1'b0, 1'b0, 1'b0,
             wb(5'd5, 1'b1, 1'b0, 32'h0, 32'h42));
        step("rs.ld.acc", ld3, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, z);
        step("rs.ld.rsp", ld3, 1'b0, 1'b1, 32'h0BAD_CAFE, 1'b0, 1'b0, 1'b0, 1'b0,
             wb(5'd11, 1'b1, 1'b1, 32'h0BAD_CAFE, 32'h400));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
